// File: rtl/xcvr_led_pkg.sv
// Shared types and constants for the transceiver LED status block.
package xcvr_led_pkg;

    // Per-channel link qualification state
    typedef enum logic [1:0] {
        DOWN = 2'd0,
        QUAL = 2'd1,
        UP   = 2'd2
    } lq_state_e;

    // LED drive level that lights the LED
    localparam logic LED_ON = 1'b1;

    // Width of each per-channel error counter
    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/xcvr_lock_qual.sv
// One transceiver channel: lock synchroniser, link qualification FSM,
// error-flash stretch counter and saturating error counter.
module xcvr_lock_qual
    import xcvr_led_pkg::*;
#(
    parameter int unsigned DEB_W = 16,
    parameter int unsigned STR_W = 22
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_rx_lock,
    input  logic                 i_err_pulse,
    input  logic                 i_err_clr,
    input  logic                 i_blink,
    output logic                 o_link_up,
    output logic                 o_led_c,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic [1:0]           sync_q, sync_d;
    lq_state_e            state_q, state_d;
    logic [DEB_W-1:0]     qcnt_q, qcnt_d;
    logic [STR_W-1:0]     str_q, str_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 link_q, link_d;
    logic                 lock_s;

    assign lock_s = sync_q[1];

    // Next-state for synchroniser, qualification FSM and counters
    always_comb begin
        sync_d  = {sync_q[0], i_rx_lock};
        state_d = state_q;
        qcnt_d  = qcnt_q;
        str_d   = str_q;
        err_d   = err_q;

        case (state_q)
            DOWN: begin
                if (lock_s) begin
                    state_d = QUAL;
                    qcnt_d  = '0;
                end
            end
            QUAL: begin
                if (!lock_s) begin
                    state_d = DOWN;
                end else if (qcnt_q == '1) begin
                    state_d = UP;
                end else begin
                    qcnt_d = qcnt_q + DEB_W'(1);
                end
            end
            UP: begin
                if (!lock_s) begin
                    state_d = DOWN;
                end
            end
            default: state_d = DOWN;
        endcase

        // Error flash only applies to a live link; a new error restarts it
        if (i_err_pulse && (state_q == UP)) begin
            str_d = '1;
        end else if (str_q != '0) begin
            str_d = str_q - STR_W'(1);
        end

        // Clear wins over a coincident pulse; count saturates
        if (i_err_clr) begin
            err_d = '0;
        end else if (i_err_pulse && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end

        link_d = (state_d == UP);
    end

    // Channel state registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q  <= '0;
            state_q <= DOWN;
            qcnt_q  <= '0;
            str_q   <= '0;
            err_q   <= '0;
            link_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            str_q   <= str_d;
            err_q   <= err_d;
            link_q  <= link_d;
        end
    end

    // LED: off when down, blink while qualifying, on when up unless flashing an error
    always_comb begin
        o_led_c = ~LED_ON;
        if (state_q == QUAL) begin
            o_led_c = i_blink;
        end else if ((state_q == UP) && (str_q == '0)) begin
            o_led_c = LED_ON;
        end
    end

    assign o_link_up = link_q;
    assign o_err_cnt = err_q;

endmodule

// File: rtl/xcvr_led_status.sv
// Transceiver LED status: heartbeat, per-channel link qualification and
// a paged LED byte for the SGPIO user LED input.
module xcvr_led_status
    import xcvr_led_pkg::*;
#(
    parameter int unsigned N_CH     = 12,
    parameter int unsigned HB_DIV_W = 27,
    parameter int unsigned DEB_W    = 16,
    parameter int unsigned STR_W    = 22,
    parameter int unsigned PG_W     = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [N_CH-1:0]             i_rx_lock,
    input  logic [N_CH-1:0]             i_err_pulse,
    input  logic                        i_err_clr,
    input  logic [PG_W-1:0]             i_page,
    output logic [7:0]                  o_led,
    output logic                        o_hb,
    output logic [N_CH-1:0]             o_link_up,
    output logic [N_CH*ERR_CNT_W-1:0]   o_err_cnt
);

    localparam int unsigned PAD_W = 4 << PG_W;

    logic [HB_DIV_W-1:0] hb_q, hb_d;
    logic [7:0]          led_q, led_d;
    logic [N_CH-1:0]     ch_led_c;
    logic [PAD_W-1:0]    led_pad_c;

    // Per-channel qualification instances
    for (genvar gi = 0; gi < int'(N_CH); gi++) begin : g_ch
        xcvr_lock_qual #(
            .DEB_W (DEB_W),
            .STR_W (STR_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rstn      (i_rstn),
            .i_rx_lock   (i_rx_lock[gi]),
            .i_err_pulse (i_err_pulse[gi]),
            .i_err_clr   (i_err_clr),
            .i_blink     (hb_q[HB_DIV_W-3]),
            .o_link_up   (o_link_up[gi]),
            .o_led_c     (ch_led_c[gi]),
            .o_err_cnt   (o_err_cnt[gi*ERR_CNT_W +: ERR_CNT_W])
        );
    end

    // Heartbeat divider and LED byte composition; pages past N_CH read as off
    always_comb begin
        hb_d      = hb_q + HB_DIV_W'(1);
        led_pad_c = PAD_W'(ch_led_c);
        led_d     = {{4{hb_d[HB_DIV_W-1]}}, led_pad_c[{i_page, 2'b00} +: 4]};
    end

    // Heartbeat and LED registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hb_q  <= '0;
            led_q <= '0;
        end else begin
            hb_q  <= hb_d;
            led_q <= led_d;
        end
    end

    assign o_hb  = hb_q[HB_DIV_W-1];
    assign o_led = led_q;

endmodule
